// File: rtl/detector_jogada.sv
// ============================================================================
//  Module      : detector_jogada
//  Description : Synchronises, debounces and one-hot-validates the four player
//                buttons; emits one accept/error pulse per debounced press.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module detector_jogada #(
    parameter int DEBOUNCE_CYCLES = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] botoes,
    input  logic       habilita,
    output logic [3:0] jogada,
    output logic       jogada_feita,
    output logic       erro_multipla,
    output logic       tem_jogada,
    output logic [3:0] db_estado
);

    localparam int c_CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ZERO = '0;

    typedef enum logic [2:0] {
        OCIOSO        = 3'd0,
        CONTANDO      = 3'd1,
        REGISTRA      = 3'd2,
        ERRO          = 3'd3,
        ESPERA_SOLTAR = 3'd4
    } estado_t;

    estado_t              r_estado;
    estado_t              w_prox_estado;
    logic [3:0]           r_s1;
    logic [3:0]           r_s2;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_prox;
    logic [3:0]           r_captura;
    logic [3:0]           w_captura_prox;
    logic [3:0]           r_jogada;
    logic [3:0]           w_jogada_prox;
    logic                 w_um_quente;

    // A value with a single bit set has no bits left after clearing its lowest one.
    assign w_um_quente = (r_captura != 4'b0000) &&
                         ((r_captura & (r_captura - 4'b0001)) == 4'b0000);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1      <= 4'b0000;
            r_s2      <= 4'b0000;
            r_cnt     <= c_CNT_ZERO;
            r_captura <= 4'b0000;
            r_jogada  <= 4'b0000;
            r_estado  <= OCIOSO;
        end else begin
            r_s1      <= botoes;
            r_s2      <= r_s1;
            r_cnt     <= w_cnt_prox;
            r_captura <= w_captura_prox;
            r_jogada  <= w_jogada_prox;
            r_estado  <= w_prox_estado;
        end
    end

    always_comb begin
        w_prox_estado  = r_estado;
        w_cnt_prox     = r_cnt;
        w_captura_prox = r_captura;
        w_jogada_prox  = r_jogada;
        case (r_estado)
            OCIOSO: begin
                if (habilita && (r_s2 != 4'b0000)) begin
                    w_prox_estado  = CONTANDO;
                    w_captura_prox = r_s2;
                    w_cnt_prox     = c_CNT_ONE;
                end
            end
            CONTANDO: begin
                // habilita is deliberately not consulted once a press is being timed.
                if (r_s2 != r_captura) begin
                    w_prox_estado = OCIOSO;
                    w_cnt_prox    = c_CNT_ZERO;
                end else if (r_cnt == c_CNT_LAST) begin
                    if (w_um_quente) begin
                        w_prox_estado = REGISTRA;
                        w_jogada_prox = r_captura;
                    end else begin
                        w_prox_estado = ERRO;
                    end
                end else begin
                    w_cnt_prox = r_cnt + c_CNT_ONE;
                end
            end
            REGISTRA, ERRO: begin
                w_prox_estado = ESPERA_SOLTAR;
                w_cnt_prox    = c_CNT_ZERO;
            end
            ESPERA_SOLTAR: begin
                if (r_s2 != 4'b0000) begin
                    w_cnt_prox = c_CNT_ZERO;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_prox_estado = OCIOSO;
                end else begin
                    w_cnt_prox = r_cnt + c_CNT_ONE;
                end
            end
            default: begin
                w_prox_estado = OCIOSO;
                w_cnt_prox    = c_CNT_ZERO;
            end
        endcase
    end

    assign jogada        = r_jogada;
    assign jogada_feita  = (r_estado == REGISTRA);
    assign erro_multipla = (r_estado == ERRO);
    assign tem_jogada    = |r_s2;
    assign db_estado     = {1'b0, r_estado};

endmodule

`default_nettype wire

// File: tb/tb_detector_jogada.sv
// ============================================================================
//  Module      : tb_detector_jogada
//  Description : Self-checking bench for detector_jogada against a cycle-level
//                behavioural model of the button conditioning rules.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_detector_jogada;

    localparam int D = 5;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] botoes = 4'b0000;
    logic       habilita = 1'b0;
    logic [3:0] jogada;
    logic       jogada_feita;
    logic       erro_multipla;
    logic       tem_jogada;
    logic [3:0] db_estado;

    detector_jogada #(.DEBOUNCE_CYCLES(D)) dut (
        .clock         (clock),
        .reset         (reset),
        .botoes        (botoes),
        .habilita      (habilita),
        .jogada        (jogada),
        .jogada_feita  (jogada_feita),
        .erro_multipla (erro_multipla),
        .tem_jogada    (tem_jogada),
        .db_estado     (db_estado)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    int dut_pulses = 0;
    int dut_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    endtask

    // Reference model: two-sample input pipe plus phase bookkeeping in terms of
    // "how many consecutive edges has the candidate/zero been seen".
    logic [3:0] pipe [2];
    logic [3:0] m_cand, m_jog;
    int         m_phase;   // 0 idle, 1 timing, 2 accepted, 3 rejected, 4 awaiting release
    int         m_seen, m_zero;

    task automatic model_edge(input logic [3:0] b, input logic h, input logic r);
        logic [3:0] synced;
        if (r) begin
            pipe[0] = 4'b0; pipe[1] = 4'b0;
            m_cand = 4'b0; m_jog = 4'b0; m_phase = 0; m_seen = 0; m_zero = 0;
        end else begin
            synced = pipe[1];
            if (m_phase == 0) begin
                if (h && synced != 4'b0) begin
                    m_phase = 1; m_cand = synced; m_seen = 1;
                end
            end else if (m_phase == 1) begin
                if (synced != m_cand) m_phase = 0;
                else begin
                    m_seen++;
                    if (m_seen == D) begin
                        if ($countones(m_cand) == 1) begin
                            m_phase = 2; m_jog = m_cand;
                        end else m_phase = 3;
                    end
                end
            end else if (m_phase == 2 || m_phase == 3) begin
                m_phase = 4; m_zero = 0;
            end else begin
                if (synced != 4'b0) m_zero = 0;
                else begin
                    m_zero++;
                    if (m_zero == D) m_phase = 0;
                end
            end
            pipe[1] = pipe[0];
            pipe[0] = b;
        end
    endtask

    task automatic compare_all();
        check("jogada",        {28'b0, jogada},        {28'b0, m_jog});
        check("jogada_feita",  {31'b0, jogada_feita},  {31'b0, (m_phase == 2)});
        check("erro_multipla", {31'b0, erro_multipla}, {31'b0, (m_phase == 3)});
        check("tem_jogada",    {31'b0, tem_jogada},    {31'b0, (pipe[1] != 4'b0)});
        check("db_estado",     {28'b0, db_estado},     m_phase);
        if (jogada_feita === 1'b1) dut_pulses++;
        if (erro_multipla === 1'b1) dut_errors++;
    endtask

    task automatic cycle(input logic [3:0] b, input logic h, input logic r);
        botoes = b; habilita = h; reset = r;
        @(posedge clock);
        model_edge(b, h, r);
        @(negedge clock);
        compare_all();
    endtask

    task automatic run(input logic [3:0] b, input logic h, input int n);
        for (int i = 0; i < n; i++) cycle(b, h, 1'b0);
    endtask

    int p0, e0;
    logic [3:0] rb;
    logic       rh;
    int         len;

    initial begin
        @(negedge clock);

        // Reset overrides the pressed buttons.
        cycle(4'b0011, 1'b0, 1'b1);
        check("rst_jogada", {28'b0, jogada}, 32'h0);
        check("rst_db_estado", {28'b0, db_estado}, 32'h0);

        // Single clean press.
        p0 = dut_pulses;
        run(4'b0100, 1'b1, 10);
        run(4'b0000, 1'b1, 10);
        check("press_pulses", dut_pulses - p0, 1);
        check("press_jogada", {28'b0, jogada}, 32'h4);

        // Bounce then a real press.
        p0 = dut_pulses;
        run(4'b0001, 1'b1, 3);
        run(4'b0000, 1'b1, 2);
        run(4'b0001, 1'b1, 10);
        run(4'b0000, 1'b1, 10);
        check("bounce_pulses", dut_pulses - p0, 1);
        check("bounce_jogada", {28'b0, jogada}, 32'h1);

        // Two buttons together.
        p0 = dut_pulses; e0 = dut_errors;
        run(4'b0011, 1'b1, 10);
        run(4'b0000, 1'b1, 10);
        check("multi_errors", dut_errors - e0, 1);
        check("multi_pulses", dut_pulses - p0, 0);
        check("multi_jogada", {28'b0, jogada}, 32'h1);

        // Disabled: level visible, no acceptance.
        p0 = dut_pulses;
        run(4'b1000, 1'b0, 10);
        check("dis_tem_jogada", {31'b0, tem_jogada}, 32'h1);
        check("dis_db_estado", {28'b0, db_estado}, 32'h0);
        check("dis_pulses", dut_pulses - p0, 0);
        run(4'b0000, 1'b0, 4);

        // Long hold, short release, full release.
        p0 = dut_pulses;
        run(4'b0010, 1'b1, 50);
        check("hold_pulses", dut_pulses - p0, 1);
        run(4'b0000, 1'b1, 2);
        run(4'b0010, 1'b1, 10);
        check("short_rel_pulses", dut_pulses - p0, 1);
        run(4'b0000, 1'b1, 10);
        run(4'b0010, 1'b1, 10);
        check("full_rel_pulses", dut_pulses - p0, 2);
        run(4'b0000, 1'b1, 10);

        // Reset in the middle of a press, button kept held.
        run(4'b0100, 1'b1, 10);
        run(4'b0000, 1'b1, 10);
        p0 = dut_pulses;
        run(4'b0010, 1'b1, 2);
        cycle(4'b0010, 1'b1, 1'b1);
        check("midrst_pulses0", dut_pulses - p0, 0);
        run(4'b0010, 1'b1, 10);
        check("midrst_pulses1", dut_pulses - p0, 1);
        check("midrst_jogada", {28'b0, jogada}, 32'h2);
        run(4'b0000, 1'b1, 10);

        // Randomised segments.
        for (int s = 0; s < 400; s++) begin
            case ($urandom_range(0, 3))
                0, 1:    rb = 4'b0001 << $urandom_range(0, 3);
                2:       rb = 4'b0000;
                default: rb = 4'($urandom);
            endcase
            rh  = ($urandom_range(0, 99) < 85);
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++)
                cycle(rb, rh, ($urandom_range(0, 199) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
